// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, reset level,
// NOP encoding, fetch FSM states and PC helpers.
package if_fetch_pkg;

    localparam int          InstAddrBus = 32;
    localparam int          InstBus     = 32;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;
    localparam logic        RstEnable   = 1'b1;
    localparam logic [31:0] NopInst     = ZeroWord;

    typedef enum logic [1:0] {
        IF_IDLE = 2'b00,
        IF_REQ  = 2'b01,
        IF_WAIT = 2'b10
    } if_state_e;

    // Low address bits are meaningless for word fetches, so both helpers drop them.
    function automatic logic [InstAddrBus-1:0] pc_align(input logic [InstAddrBus-1:0] pc);
        return {pc[InstAddrBus-1:2], 2'b00};
    endfunction

    function automatic logic [InstAddrBus-1:0] pc_inc(input logic [InstAddrBus-1:0] pc);
        return {pc[InstAddrBus-1:2] + 30'd1, 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_skid_buf.sv
// One-entry pc/inst/valid holding buffer used by the fetch stage to park a
// response that arrives while the IF/ID output is held by stall.
module if_skid_buf
    import if_fetch_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [InstAddrBus-1:0] in_pc,
    input  logic [InstBus-1:0]     in_inst,
    output logic                   valid,
    output logic [InstAddrBus-1:0] pc,
    output logic [InstBus-1:0]     inst
);

    // A push in the same cycle as a pop replaces the entry being drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            valid <= 1'b0;
            pc    <= ZeroWord;
            inst  <= NopInst;
        end else if (flush) begin
            valid <= 1'b0;
            inst  <= NopInst;
        end else if (push) begin
            valid <= 1'b1;
            pc    <= in_pc;
            inst  <= in_inst;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time and
// presents a registered pc/inst/valid to IF/ID. Optional skid buffer: IF_SKID_BUF_EN.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        if_valid_o
);

    if_state_e              state, state_next;
    logic [InstAddrBus-1:0] pc, pend_pc, out_pc;
    logic [InstBus-1:0]     out_inst;
    logic                   out_valid, drop, req_hold;
    logic                   req, hold_out, block_req;
    logic                   rsp_fire, rsp_usable, out_load_rsp, accept;

`ifdef IF_SKID_BUF_EN
    logic                   skid_valid, skid_push, skid_pop;
    logic [InstAddrBus-1:0] skid_pc;
    logic [InstBus-1:0]     skid_inst;

    if_skid_buf u_skid_buf (
        .clk     (clk),
        .rst     (rst),
        .push    (skid_push),
        .pop     (skid_pop),
        .flush   (branch_flag_i),
        .in_pc   (pc),
        .in_inst (imem_rdata_i),
        .valid   (skid_valid),
        .pc      (skid_pc),
        .inst    (skid_inst)
    );
`endif

    // A request already on the bus is never withdrawn; only fresh requests are
    // held back while the output is frozen and there is nowhere to put a reply.
    always_comb begin
        hold_out   = out_valid && stall_i;
        rsp_fire   = (state == IF_WAIT) && imem_rvalid_i;
        rsp_usable = rsp_fire && !drop && !branch_flag_i;
`ifdef IF_SKID_BUF_EN
        block_req    = hold_out && skid_valid;
        skid_pop     = skid_valid && !stall_i && !branch_flag_i;
        skid_push    = rsp_usable && (hold_out ? !skid_valid : skid_valid);
        out_load_rsp = rsp_usable && !hold_out && !skid_valid;
        accept       = skid_push || out_load_rsp;
`else
        block_req    = hold_out;
        out_load_rsp = rsp_usable && !hold_out;
        accept       = out_load_rsp;
`endif
        req = (state == IF_REQ) && (req_hold || !block_req);
    end

    always_comb begin
        state_next = state;
        case (state)
            IF_IDLE: state_next = IF_REQ;
            IF_REQ:  if (req && imem_gnt_i) state_next = IF_WAIT;
            IF_WAIT: if (imem_rvalid_i)
                         state_next = (stall_i && !branch_flag_i) ? IF_IDLE : IF_REQ;
            default: state_next = IF_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) state <= IF_IDLE;
        else                  state <= state_next;
    end

    // A redirect while the old request waits for gnt keeps that request intact;
    // the target is parked in pend_pc and installed once the stale reply is dropped.
    // A usable reply that cannot be stored is simply refetched later (pc unchanged).
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            pc       <= RESET_PC;
            pend_pc  <= RESET_PC;
            drop     <= 1'b0;
            req_hold <= 1'b0;
        end else begin
            req_hold <= req && !imem_gnt_i;
            if (branch_flag_i) begin
                pend_pc <= pc_align(branch_target_i);
                if (req && !imem_gnt_i) begin
                    drop <= 1'b1;
                end else if ((req && imem_gnt_i) || (state == IF_WAIT && !imem_rvalid_i)) begin
                    pc   <= pc_align(branch_target_i);
                    drop <= 1'b1;
                end else begin
                    pc   <= pc_align(branch_target_i);
                    drop <= 1'b0;
                end
            end else if (rsp_fire) begin
                drop <= 1'b0;
                if (drop)        pc <= pend_pc;
                else if (accept) pc <= pc_inc(pc);
            end
        end
    end

    // Output register: redirect wins over stall; with no new word and no stall
    // the stage emits a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            out_pc    <= ZeroWord;
            out_inst  <= ZeroWord;
            out_valid <= 1'b0;
        end else if (branch_flag_i) begin
            out_inst  <= NopInst;
            out_valid <= 1'b0;
`ifdef IF_SKID_BUF_EN
        end else if (skid_pop) begin
            out_pc    <= skid_pc;
            out_inst  <= skid_inst;
            out_valid <= 1'b1;
`endif
        end else if (out_load_rsp) begin
            out_pc    <= pc;
            out_inst  <= imem_rdata_i;
            out_valid <= 1'b1;
        end else if (!stall_i) begin
            out_inst  <= NopInst;
            out_valid <= 1'b0;
        end
    end

    assign imem_req_o  = req;
    assign imem_addr_o = pc;
    assign if_pc_o     = out_pc;
    assign if_inst_o   = out_inst;
    assign if_valid_o  = out_valid;

endmodule
